rr_bus_mux: RTL and testbench

Registered, round-robin arbitrated N-way bus multiplexer: the parametrised successor of the two-input combinational `Multiplexer`. It sits between several bus masters (fetch unit, ALU writeback, I/O) and a shared destination register. Requesters present data with a request line; the block grants one at a time, registers the selected data, and enforces a fairness limit on grant length.

---
 rtl/rr_bus_mux_pkg.sv | 12 +
 rtl/rr_bus_mux_picker.sv | 26 ++
 rtl/rr_bus_mux.sv | 73 +++++++
 tb/tb_rr_bus_mux.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rr_bus_mux_pkg.sv
// rr_bus_mux_pkg: shared defaults, arbiter state type and clog2 helper for rr_bus_mux
package rr_bus_mux_pkg;
  localparam int def_input_width = 8;
  localparam int def_channels = 4;
  localparam int def_max_hold = 4;
  typedef enum logic {IDLE, GRANTED} arb_state_e;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r < 1 ? 1 : r;
  endfunction
endpackage

// File: rtl/rr_bus_mux_picker.sv
// rr_picker: combinational circular priority search starting at pointer
module rr_picker #(
  parameter int channels = 4,
  parameter int selWidth = 2
) (
  input  logic [channels-1:0] req,
  input  logic [selWidth-1:0] pointer,
  output logic                found,
  output logic [selWidth-1:0] winner
);
  int k;
  always_comb begin
    found = 1'b0;
    winner = '0;
    k = 0;
    // walk from farthest to nearest so the nearest requester is written last
    for (int i = channels - 1; i >= 0; i--) begin
      k = int'(pointer) + i;
      k = k >= channels ? k - channels : k;
      if (req[selWidth'(k)]) begin
        found = 1'b1;
        winner = selWidth'(k);
      end
    end
  end
endmodule

// File: rtl/rr_bus_mux.sv
// rr_bus_mux: registered round-robin N-way bus multiplexer with grant-length fairness limit
module rr_bus_mux import rr_bus_mux_pkg::*; #(
  parameter int inputWidth = def_input_width,
  parameter int channels = def_channels,
  parameter int maxHold = def_max_hold,
  localparam int selWidth = clog2(channels)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [channels*inputWidth-1:0] in,
  input  logic [channels-1:0]            req,
  output logic [channels-1:0]            grant,
  output logic [inputWidth-1:0]          out,
  output logic                           outValid,
  output logic [selWidth-1:0]            outChannel
);
  localparam int hold_width = clog2(maxHold + 1);
  localparam logic [hold_width-1:0] hold_one = hold_width'(1);
  localparam logic [hold_width-1:0] hold_last = hold_width'(maxHold == 0 ? 0 : maxHold - 1);
  localparam logic [selWidth-1:0] sel_one = selWidth'(1);
  localparam logic [selWidth-1:0] last_channel = selWidth'(channels - 1);
  localparam logic [channels-1:0] one_hot = channels'(1);
  arb_state_e state, state_n;
  logic [selWidth-1:0] cur, cur_n, pointer, pointer_n, winner;
  logic [hold_width-1:0] hold_count, hold_n;
  logic [channels-1:0] others, search;
  logic expire, keep, found;
  assign others = req & ~grant;
  assign expire = maxHold != 0 && hold_count == hold_last && |others;
  assign keep = state == GRANTED && req[cur] && !expire;
  // an expiring owner is masked out so it can only win again when alone
  assign search = expire ? others : req;
  rr_picker #(.channels(channels), .selWidth(selWidth)) picker (
    .req(search),
    .pointer(pointer),
    .found(found),
    .winner(winner)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      cur <= '0;
      pointer <= '0;
      hold_count <= '0;
    end else begin
      state <= state_n;
      grant <= state_n == GRANTED ? one_hot << cur_n : '0;
      cur <= cur_n;
      pointer <= pointer_n;
      hold_count <= hold_n;
    end
  end
  always_comb begin
    state_n = keep || found ? GRANTED : IDLE;
    cur_n = keep || !found ? cur : winner;
    pointer_n = keep || !found ? pointer : winner == last_channel ? '0 : winner + sel_one;
    hold_n = keep ? (&hold_count ? hold_count : hold_count + hold_one) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
      outValid <= 1'b0;
      outChannel <= '0;
    end else if (state == GRANTED && req[cur]) begin
      out <= in[int'(cur)*inputWidth +: inputWidth];
      outChannel <= cur;
      outValid <= 1'b1;
    end else begin
      outValid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_bus_mux.sv
// tb_rr_bus_mux: directed self-checking bench for rr_bus_mux (maxHold=4 and maxHold=0 instances)
module tb_rr_bus_mux;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] din;
  logic [3:0] req, req0;
  logic [3:0] grant, grant0;
  logic [7:0] out, out0;
  logic out_valid, out_valid0;
  logic [1:0] out_channel, out_channel0;
  int passed = 0;
  int total = 0;
  int seq [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 3, 3, 3, 3, 0, 0, 0, 0};
  rr_bus_mux #(.inputWidth(8), .channels(4), .maxHold(4)) dut (
    .clk(clk), .reset(reset), .in(din), .req(req),
    .grant(grant), .out(out), .outValid(out_valid), .outChannel(out_channel)
  );
  rr_bus_mux #(.inputWidth(8), .channels(4), .maxHold(0)) dut0 (
    .clk(clk), .reset(reset), .in(din), .req(req0),
    .grant(grant0), .out(out0), .outValid(out_valid0), .outChannel(out_channel0)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  initial begin
    reset = 1'b1;
    req = 4'b1111;
    req0 = 4'b1111;
    din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    tick();
    chk("rst_grant", grant, 4'b0000);
    chk("rst_out", out, 8'h00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_chan", out_channel, 2'd0);
    chk("rst_grant0", grant0, 4'b0000);
    reset = 1'b0;
    req = 4'b0000;
    req0 = 4'b0000;
    tick();
    req = 4'b0100;
    din = {8'hD3, 8'hAA, 8'hB1, 8'hA0};
    tick();
    chk("single_grant_e1", grant, 4'b0100);
    chk("single_valid_e1", out_valid, 1'b0);
    tick();
    chk("single_out_e2", out, 8'hAA);
    chk("single_chan_e2", out_channel, 2'd2);
    chk("single_valid_e2", out_valid, 1'b1);
    req = 4'b0000;
    tick();
    chk("drop_grant", grant, 4'b0000);
    chk("drop_valid", out_valid, 1'b0);
    chk("drop_out_hold", out, 8'hAA);
    din = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1011;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("cont_grant_%0d", i), grant, 4'b0001 << seq[i]);
      if (i > 0) begin
        chk($sformatf("cont_valid_%0d", i), out_valid, 1'b1);
        chk($sformatf("cont_chan_%0d", i), out_channel, seq[i-1]);
      end
    end
    chk("cont_out_ch0", out, 8'hA0);
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("nocont_grant_%0d", i), grant, 4'b0010);
      if (i > 0) begin
        chk($sformatf("nocont_valid_%0d", i), out_valid, 1'b1);
        chk($sformatf("nocont_out_%0d", i), out, 8'hB1);
      end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b0001;
    tick();
    chk("ho_grant0", grant, 4'b0001);
    req = 4'b0101;
    tick();
    chk("ho_keep", grant, 4'b0001);
    chk("ho_out_a0", out, 8'hA0);
    req = 4'b0100;
    tick();
    chk("ho_switch", grant, 4'b0100);
    chk("ho_bubble", out_valid, 1'b0);
    tick();
    chk("ho_valid", out_valid, 1'b1);
    chk("ho_out_c2", out, 8'hC2);
    chk("ho_chan", out_channel, 2'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_grant", grant, 4'b0000);
    chk("midrst_valid", out_valid, 1'b0);
    req = 4'b0000;
    req0 = 4'b0001;
    tick();
    chk("mh0_grant", grant0, 4'b0001);
    req0 = 4'b0011;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("mh0_hold_%0d", i), grant0, 4'b0001);
    end
    chk("mh0_valid", out_valid0, 1'b1);
    req0 = 4'b0010;
    tick();
    chk("mh0_switch", grant0, 4'b0010);
    chk("mh0_bubble", out_valid0, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
